// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation encodings and FSM state constants for alu_nbit_seq
package alu_pkg;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_MUL   = 2'b10;
   localparam logic [1:0] OP_LOGIC = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_MUL  = 2'd1;
   localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/alu_nbit_seq_if.sv
// rtl/alu_nbit_seq_if.sv - request/result bundle between a requester and alu_nbit_seq
interface alu_nbit_seq_if #(
   parameter int WIDTH = 3
);
   logic                 start;
   logic [1:0]           sel;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [2*WIDTH-1:0]   op;
   logic                 busy;
   logic                 done;

   modport master (
      output start, sel, A, B,
      input  op, busy, done
   );

   modport slave (
      input  start, sel, A, B,
      output op, busy, done
   );
endinterface

// File: rtl/alu_shift_add_mul.sv
// rtl/alu_shift_add_mul.sv - unsigned shift-add multiplier datapath, one multiplier bit per step
module alu_shift_add_mul #(
   parameter int WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product_next,
   output logic                 last
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   // Accumulator value after the current step; the FSM latches it on the final step.
   assign product_next = acc + (mplier[0] ? mcand : '0);
   assign last         = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (step) begin
         acc    <= product_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - sequential ALU: single-cycle ADD/SUB/LOGIC, WIDTH-cycle shift-add MUL
module alu_nbit_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic          clk,
   input  logic          rst,
   alu_nbit_seq_if.slave bus
);

   state_t               state;
   logic [2*WIDTH-1:0]   op_q;
   logic [2*WIDTH-1:0]   quick_res;
   logic [2*WIDTH-1:0]   product_next;
   logic                 load;
   logic                 step;
   logic                 last;

   assign load = (state == S_IDLE) && bus.start && (bus.sel == OP_MUL);
   assign step = (state == S_MUL);

   alu_shift_add_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .step         (step),
      .a            (bus.A),
      .b            (bus.B),
      .product_next (product_next),
      .last         (last)
   );

   // Zero-extending before subtracting yields the sign-extended 2*WIDTH difference.
   always_comb begin
      quick_res = '0;
      case (bus.sel)
         OP_ADD:   quick_res = {{WIDTH{1'b0}}, bus.A} + {{WIDTH{1'b0}}, bus.B};
         OP_SUB:   quick_res = {{WIDTH{1'b0}}, bus.A} - {{WIDTH{1'b0}}, bus.B};
         OP_LOGIC: quick_res = {bus.A | bus.B, bus.A & bus.B};
         default:  quick_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         op_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.sel == OP_MUL) begin
                     state <= S_MUL;
                  end else begin
                     op_q  <= quick_res;
                     state <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               if (last) begin
                  op_q  <= product_next;
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.op   = op_q;
   assign bus.busy = (state != S_IDLE);
   assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - self-checking bench for alu_nbit_seq at WIDTH=3 and WIDTH=8
module tb_alu_nbit_seq;

   logic clk;
   logic rst;
   int   total;
   int   passed;

   alu_nbit_seq_if #(.WIDTH(3)) bus3 ();
   alu_nbit_seq_if #(.WIDTH(8)) bus8 ();

   alu_nbit_seq #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
   alu_nbit_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] model(input int w, input logic [1:0] s, input int a, input int b);
      int r;
      int mask;
      mask = (1 << (2 * w)) - 1;
      case (s)
         2'b00:   r = a + b;
         2'b01:   r = a - b;
         2'b10:   r = a * b;
         default: r = ((a | b) << w) | (a & b);
      endcase
      return 16'(r & mask);
   endfunction

   function automatic logic [15:0] get_op(input int w);
      return (w == 3) ? 16'(bus3.op) : bus8.op;
   endfunction

   function automatic logic get_done(input int w);
      return (w == 3) ? bus3.done : bus8.done;
   endfunction

   function automatic logic get_busy(input int w);
      return (w == 3) ? bus3.busy : bus8.busy;
   endfunction

   task automatic drive(input int w, input logic st, input logic [1:0] s, input int a, input int b);
      if (w == 3) begin
         bus3.start = st; bus3.sel = s; bus3.A = a[2:0]; bus3.B = b[2:0];
      end else begin
         bus8.start = st; bus8.sel = s; bus8.A = a[7:0]; bus8.B = b[7:0];
      end
   endtask

   // One request from IDLE: latency, result, result-hold while working, busy coverage.
   task automatic run(input int w, input logic [1:0] s, input int a, input int b,
                      input logic [15:0] exp_op, input string tag);
      int          lat;
      int          exp_lat;
      logic        hold_ok;
      logic        busy_ok;
      logic [15:0] prev;
      prev    = get_op(w);
      exp_lat = (s == 2'b10) ? w + 1 : 1;
      drive(w, 1'b1, s, a, b);
      @(posedge clk); #1;
      drive(w, 1'b0, 2'($urandom), int'($urandom), int'($urandom));
      lat     = 1;
      hold_ok = 1'b1;
      busy_ok = 1'b1;
      while (!get_done(w) && lat < 40) begin
         if (get_op(w) !== prev) hold_ok = 1'b0;
         if (!get_busy(w)) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (!get_busy(w)) busy_ok = 1'b0;
      check({tag, " latency"}, 16'(lat), 16'(exp_lat));
      check({tag, " op"}, get_op(w), exp_op);
      check({tag, " hold"}, {15'd0, hold_ok}, 16'd1);
      check({tag, " busy"}, {15'd0, busy_ok}, 16'd1);
      @(posedge clk); #1;
      check({tag, " idle"}, {14'd0, get_busy(w), get_done(w)}, 16'd0);
   endtask

   initial begin
      logic        no_done;
      logic [1:0]  s;
      int          a;
      int          b;
      total  = 0;
      passed = 0;
      rst    = 1'b1;
      drive(3, 1'b0, 2'b00, 0, 0);
      drive(8, 1'b0, 2'b00, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset op3", get_op(3), 16'd0);
      check("reset op8", get_op(8), 16'd0);
      check("reset busy/done3", {14'd0, get_busy(3), get_done(3)}, 16'd0);
      check("reset busy/done8", {14'd0, get_busy(8), get_done(8)}, 16'd0);

      run(3, 2'b00, 2, 7, 16'b001001, "add3");
      run(3, 2'b01, 2, 7, 16'b111011, "sub3");
      run(3, 2'b11, 2, 7, 16'b111010, "logic3");
      run(3, 2'b10, 2, 7, 16'b001110, "mul3");
      run(8, 2'b10, 255, 255, 16'hFE01, "mul8");

      // A second start during MUL must not be queued or alter the product.
      drive(3, 1'b1, 2'b10, 5, 6);
      @(posedge clk); #1;
      drive(3, 1'b0, 2'b10, 5, 6);
      @(posedge clk); #1;
      drive(3, 1'b1, 2'b00, 7, 7);
      @(posedge clk); #1;
      drive(3, 1'b0, 2'b00, 0, 0);
      @(posedge clk); #1;
      check("repulse done", {15'd0, get_done(3)}, 16'd1);
      check("repulse op", get_op(3), 16'd30);
      @(posedge clk); #1;
      check("repulse ignored", {14'd0, get_busy(3), get_done(3)}, 16'd0);
      check("repulse op kept", get_op(3), 16'd30);

      // Reset on the second MUL cycle abandons the multiply.
      drive(3, 1'b1, 2'b10, 3, 3);
      @(posedge clk); #1;
      drive(3, 1'b0, 2'b10, 3, 3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst op", get_op(3), 16'd0);
      check("midrst busy/done", {14'd0, get_busy(3), get_done(3)}, 16'd0);
      no_done = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (get_done(3) || get_busy(3)) no_done = 1'b0;
      end
      check("midrst no done", {15'd0, no_done}, 16'd1);
      run(3, 2'b00, 1, 1, 16'd2, "post rst add");

      // start held high: accepted every other edge.
      drive(3, 1'b1, 2'b00, 3, 4);
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) drive(3, 1'b0, 2'b00, 3, 4);
         @(posedge clk); #1;
         check($sformatf("held done k=%0d", k), {15'd0, get_done(3)}, 16'(k % 2));
         if (k % 2 == 1) check($sformatf("held op k=%0d", k), get_op(3), 16'd7);
      end
      @(posedge clk); #1;
      check("held stopped", {14'd0, get_busy(3), get_done(3)}, 16'd0);

      for (int i = 0; i < 16; i++) begin
         s = 2'($urandom_range(0, 3));
         a = int'($urandom_range(0, 7));
         b = int'($urandom_range(0, 7));
         run(3, s, a, b, model(3, s, a, b), $sformatf("rnd3 #%0d", i));
      end
      for (int i = 0; i < 10; i++) begin
         s = 2'($urandom_range(0, 3));
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         run(8, s, a, b, model(8, s, a, b), $sformatf("rnd8 #%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_nbit_seq.md
ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one operation; sampled only in IDLE.
REQ-005 The block SHALL have port sel, input, 2 bits: operation select; 00 ADD, 01 SUB, 10 MUL, 11 LOGIC.
REQ-006 The block SHALL have port A, input, WIDTH bits: unsigned operand A.
REQ-007 The block SHALL have port B, input, WIDTH bits: unsigned operand B.
REQ-008 The block SHALL have port op, output, 2*WIDTH bits: registered result.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid op.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, MUL, DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL capture sel, A and B into internal registers at that edge.
- Later changes on sel, A and B SHALL have no effect until the next accepted start.
REQ-013 For ADD, SUB and LOGIC, the block SHALL write op and enter DONE at the capturing edge, so done is high in the following cycle (latency 1).
REQ-014 ADD SHALL produce op = A + B, zero-extended to 2*WIDTH; the carry appears in bit WIDTH.
REQ-015 SUB SHALL produce op = A - B as a 2*WIDTH-bit two's-complement value.
- Negative results SHALL be sign-extended.
REQ-016 LOGIC SHALL produce op[WIDTH-1:0] = A AND B and op[2*WIDTH-1:WIDTH] = A OR B.
REQ-017 MUL SHALL be unsigned shift-add and SHALL enter MUL at the capturing edge.
- The block SHALL spend exactly WIDTH cycles in MUL, processing one multiplier bit per edge, LSB first.
- It SHALL then enter DONE with op = A*B; done is high WIDTH+1 cycles after the capturing edge.
REQ-018 During MUL, op SHALL hold the previous result and SHALL NOT expose partial products.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 start SHALL be ignored while busy=1, including in the DONE cycle.
- A start held high SHALL therefore be accepted again on the first edge in IDLE.
REQ-021 op SHALL hold its value between results until the next DONE or reset.
REQ-022 The MUL iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL be cleared on every accept.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set state=IDLE, op=0, busy=0, done=0, and clear the captured operands and counter.
- Reset SHALL take priority over start.
REQ-024 Reset asserted mid-MUL SHALL abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-025 Package alu_pkg SHALL hold the sel encodings (OP_ADD, OP_SUB, OP_MUL, OP_LOGIC) and the FSM state typedef.
REQ-026 The shift-add datapath SHALL live in one sub-module, alu_shift_add_mul, containing the accumulator, shifting multiplicand and counter.
- It SHALL take load and step controls from the FSM.

Verification
REQ-027 The bench SHALL cover these directed scenarios, with WIDTH=3, A=3'b010, B=3'b111:
- ADD -> op=6'b001001, done one cycle after start.
- SUB -> op=6'b111011.
- LOGIC -> op=6'b111010.
- MUL -> op=6'b001110, with done exactly 4 cycles after the accepting edge.
REQ-028 WIDTH=8, MUL A=255 B=255 -> op=16'hFE01, done 9 cycles after accept; busy high for all 9 cycles.
REQ-029 MUL started, start re-pulsed with new operands during MUL -> second request ignored; op=original product.
REQ-030 rst asserted on the 2nd MUL cycle -> op=0, busy=0, no done; next ADD 1+1 -> op=2.
REQ-031 start held high continuously with ADD 3+4 -> done pulses every 2 cycles, op=7 each time.
